// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loader_state_t : frame-parsing FSM states
//   LEN_BYTES      : number of big-endian length bytes at the head of a frame
//   CSUM_WIDTH     : width of the running checksum (sum modulo 2**CSUM_WIDTH)
package program_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int CSUM_WIDTH = 8;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler for the program loader.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   byte_valid  : a data byte is accepted this cycle
//   byte_data   : the accepted byte; the first byte of a word lands in [31:24]
//   last_byte   : combinational, this accepted byte completes a word
//   word        : most recently completed word (held until the next one)
//   word_done   : one-cycle pulse in the cycle after the completing byte
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;
  logic        done_q;

  assign last_byte = byte_valid && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (byte_valid) begin
        shift_q <= {shift_q[15:0], byte_data};
        idx_q   <= idx_q + 2'd1;
        // The word is captured separately so it stays stable while the
        // next word's first byte shifts in during the write cycle.
        if (idx_q == 2'd3) begin
          word_q <= {shift_q, byte_data};
          done_q <= 1'b1;
        end
      end
    end
  end

  assign word      = word_q;
  assign word_done = done_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader in front of the instruction memory.
// Receives a frame LEN_HI LEN_LO <4*N data bytes> CSUM, writes N big-endian
// words to instruction memory from address 0, and releases the core
// (cpu_run) only after the checksum matches.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rx_data/rx_valid      : incoming byte stream
//   rx_ready              : loader can accept a byte this cycle
//   imem_we/addr/wdata    : one-cycle word write, byte address word aligned
//   cpu_run               : frame loaded and verified, core may execute
//   load_error            : sticky frame error (length, checksum, timeout)
//   words_loaded          : words written in the current frame
//   state_dbg             : current FSM state
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready are
// both high; rx_ready is registered and is never withdrawn by rx_valid, and
// rx_valid/rx_data are ignored while rx_ready is low.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                imem_we,
  output logic [31:0]         imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                cpu_run,
  output logic                load_error,
  output logic [ADDR_WIDTH:0] words_loaded,
  output loader_state_t       state_dbg
);

  localparam int LW = 8 * LEN_BYTES;

  loader_state_t         state_q, state_d;
  logic                  rx_ready_q;
  logic [LW-1:0]         len_q;
  logic [CSUM_WIDTH-1:0] csum_q;
  logic [31:0]           tcnt_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [31:0]           addr_q;

  logic          xfer;
  logic          timed;
  logic          timeout_hit;
  logic [LW-1:0] len_now;
  logic          last_word;
  logic          data_byte;
  logic          last_byte;

  assign xfer        = rx_valid && rx_ready_q;
  assign timed       = (state_q == LEN_LO) || (state_q == DATA) || (state_q == CHECK);
  assign timeout_hit = timed && !xfer && (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign len_now     = {len_q[LW-9:0], rx_data};
  assign last_word   = (LW'(words_q) + LW'(1)) == len_q;
  assign data_byte   = xfer && (state_q == DATA);

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word       (imem_wdata),
    .word_done  (imem_we)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN_HI: if (xfer) state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_now == '0)                  state_d = CHECK;
          else if (len_now > LW'(MAX_WORDS))  state_d = ERROR;
          else                                state_d = DATA;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      DATA: begin
        if (last_byte && last_word) state_d = CHECK;
        else if (timeout_hit)       state_d = ERROR;
      end
      CHECK: begin
        if (xfer)             state_d = (rx_data == csum_q) ? DONE : ERROR;
        else if (timeout_hit) state_d = ERROR;
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LEN_HI;
      rx_ready_q <= 1'b0;
      len_q      <= '0;
      csum_q     <= '0;
      tcnt_q     <= 32'd0;
      words_q    <= '0;
      addr_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      // Ready follows the next state so no byte is taken once the frame ends.
      rx_ready_q <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                    (state_d == DATA)   || (state_d == CHECK);
      tcnt_q     <= (timed && !xfer) ? tcnt_q + 32'd1 : 32'd0;
      if (xfer && ((state_q == LEN_HI) || (state_q == LEN_LO)))
        len_q <= len_now;
      if (xfer && ((state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA)))
        csum_q <= csum_q + rx_data;
      // Address is taken from the pre-increment count; both update on the
      // edge that completes the word, so the write cycle shows the new count.
      if (last_byte) begin
        addr_q  <= 32'({words_q, 2'b00});
        words_q <= words_q + 1'b1;
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_addr    = addr_q;
  assign cpu_run      = (state_q == DONE);
  assign load_error   = (state_q == ERROR);
  assign words_loaded = words_q;
  assign state_dbg    = state_q;

endmodule
